elastic_buffer_skp_delete_ctrl: RTL

- Write-domain front end of the RX elastic buffer. Sits between the deserializer/symbol aligner and the write pointer control.
- Detects SKP ordered sets (COM followed by SKP symbols) in the incoming 10-bit symbol stream.
- Computes buffer fill from the synchronized gray read pointer and the current write address.
- Deletes at most one SKP per ordered set when fill exceeds the high watermark. The deletion is a suppressed write plus a delete request to the write pointer control.

---
 rtl/elastic_buffer_skp_delete_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/elastic_buffer_skp_delete_ctrl.sv
// ---------------------------------------------------------------------------
// elastic_buffer_skp_delete_ctrl
//
// Write-domain front end of the RX elastic buffer. Watches the aligned 10b
// symbol stream for SKP ordered sets (COM followed by SKPs), tracks buffer
// occupancy from the synchronized gray read pointer, and removes at most one
// SKP per ordered set when the buffer is running too full. A removal is a
// suppressed write plus a delete request to the write pointer control.
//
// Ports:
//   write_clk            recovered write clock
//   rst_n                asynchronous active-low reset
//   i_data_in            aligned 10b symbol
//   i_data_valid         i_data_in qualifier
//   i_buffer_mode        1 = elastic (deletion allowed), 0 = pass-through
//   i_gray_read_pointer  gray read pointer, already synchronized to write_clk
//   i_write_address      binary write pointer (wrap bit in MSB)
//   o_data_out           registered symbol to the buffer
//   o_write_en           registered write strobe for o_data_out
//   o_delete_req         1-cycle pulse, write pointer must not advance
//   o_skp_removed        1-cycle pulse per deleted SKP
//   o_fill_level         registered occupancy
//   o_os_error           1-cycle pulse, SKP count exceeded MAX_SKP
// ---------------------------------------------------------------------------
module elastic_buffer_skp_delete_ctrl #(
  parameter int DATA_WIDTH     = 10,
  parameter int BUFFER_DEPTH   = 16,
  parameter int HIGH_WATERMARK = 10,
  parameter int MAX_SKP        = 5
) (
  input  logic                            write_clk,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           i_data_in,
  input  logic                            i_data_valid,
  input  logic                            i_buffer_mode,
  input  logic [$clog2(BUFFER_DEPTH):0]   i_gray_read_pointer,
  input  logic [$clog2(BUFFER_DEPTH):0]   i_write_address,
  output logic [DATA_WIDTH-1:0]           o_data_out,
  output logic                            o_write_en,
  output logic                            o_delete_req,
  output logic                            o_skp_removed,
  output logic [$clog2(BUFFER_DEPTH):0]   o_fill_level,
  output logic                            o_os_error
);

  localparam int A  = $clog2(BUFFER_DEPTH);
  localparam int PW = A + 1;
  // Counter wide enough to hold MAX_SKP+1 so overflow is observable.
  localparam int CW = $clog2(MAX_SKP + 2);

  localparam logic [PW-1:0] HWM_C     = PW'(HIGH_WATERMARK);
  localparam logic [CW-1:0] MAX_SKP_C = CW'(MAX_SKP);

  localparam logic [DATA_WIDTH-1:0] COM_P = DATA_WIDTH'(10'b0011111010);
  localparam logic [DATA_WIDTH-1:0] COM_N = DATA_WIDTH'(10'b1100000101);
  localparam logic [DATA_WIDTH-1:0] SKP_P = DATA_WIDTH'(10'b0011110100);
  localparam logic [DATA_WIDTH-1:0] SKP_N = DATA_WIDTH'(10'b1100001011);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COM_SEEN = 2'd1,
    S_SKP_OS   = 2'd2
  } state_t;

  state_t                r_state;
  logic [CW-1:0]         r_skp_cnt;
  logic                  r_deleted;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_write_en;
  logic                  r_delete_req;
  logic                  r_skp_removed;
  logic [PW-1:0]         r_fill;
  logic                  r_os_error;

  logic                  w_is_com;
  logic                  w_is_skp;
  logic [PW-1:0]         w_rd_bin;
  logic [PW-1:0]         w_fill;
  logic [CW-1:0]         w_cnt_inc;
  logic                  w_overflow;
  logic                  w_delete;

  assign w_is_com = (i_data_in == COM_P) || (i_data_in == COM_N);
  assign w_is_skp = (i_data_in == SKP_P) || (i_data_in == SKP_N);

  // Gray to binary: each bit is the XOR of all gray bits at or above it.
  always_comb begin
    w_rd_bin = '0;
    w_rd_bin[PW-1] = i_gray_read_pointer[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      w_rd_bin[i] = w_rd_bin[i+1] ^ i_gray_read_pointer[i];
    end
  end

  // Modulo 2^(A+1) subtraction gives correct occupancy across pointer wrap.
  assign w_fill = i_write_address - w_rd_bin;

  assign w_cnt_inc  = (r_skp_cnt == '1) ? r_skp_cnt : r_skp_cnt + 1'b1;
  assign w_overflow = (r_state == S_SKP_OS) && w_is_skp && (w_cnt_inc > MAX_SKP_C);

  // Only SKPs after the first can reach S_SKP_OS evaluation, so the first
  // SKP of every ordered set is always written. Uses last cycle's fill.
  assign w_delete = (r_state == S_SKP_OS) && w_is_skp && i_data_valid &&
                    i_buffer_mode && !r_deleted && (r_fill > HWM_C) && !w_overflow;

  always_ff @(posedge write_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_skp_cnt     <= '0;
      r_deleted     <= 1'b0;
      r_data_out    <= '0;
      r_write_en    <= 1'b0;
      r_delete_req  <= 1'b0;
      r_skp_removed <= 1'b0;
      r_fill        <= '0;
      r_os_error    <= 1'b0;
    end else begin
      r_fill        <= w_fill;
      r_delete_req  <= w_delete;
      r_skp_removed <= w_delete;
      r_os_error    <= 1'b0;

      // A deleted SKP leaves data_out untouched so the buffer sees no change.
      if (w_delete) begin
        r_write_en <= 1'b0;
      end else begin
        r_data_out <= i_data_in;
        r_write_en <= i_data_valid;
      end

      if (i_data_valid) begin
        case (r_state)
          S_IDLE: begin
            r_skp_cnt <= '0;
            r_deleted <= 1'b0;
            r_state   <= w_is_com ? S_COM_SEEN : S_IDLE;
          end
          S_COM_SEEN: begin
            r_deleted <= 1'b0;
            if (w_is_skp) begin
              r_state   <= S_SKP_OS;
              r_skp_cnt <= CW'(1);
            end else if (w_is_com) begin
              r_state   <= S_COM_SEEN;
              r_skp_cnt <= '0;
            end else begin
              r_state   <= S_IDLE;
              r_skp_cnt <= '0;
            end
          end
          S_SKP_OS: begin
            if (w_is_skp) begin
              if (w_overflow) begin
                r_os_error <= 1'b1;
                r_state    <= S_IDLE;
                r_skp_cnt  <= '0;
                r_deleted  <= 1'b0;
              end else begin
                r_skp_cnt <= w_cnt_inc;
                if (w_delete) begin
                  r_deleted <= 1'b1;
                end
              end
            end else begin
              r_state   <= w_is_com ? S_COM_SEEN : S_IDLE;
              r_skp_cnt <= '0;
              r_deleted <= 1'b0;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_skp_cnt <= '0;
            r_deleted <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_data_out    = r_data_out;
  assign o_write_en    = r_write_en;
  assign o_delete_req  = r_delete_req;
  assign o_skp_removed = r_skp_removed;
  assign o_fill_level  = r_fill;
  assign o_os_error    = r_os_error;

endmodule
